// File: rtl/video_fb_sdram_arbiter.sv
// Three-port Avalon-MM arbiter in front of the frame-buffer SDRAM controller.
// m0 = display line fetcher (read), m1 = pixel writer (write), m2 = CPU (rd/wr).
// Commands and responses pass through combinationally; read responses are
// steered back to their issuer by an in-order 1-bit tag FIFO (0 = m0, 1 = m2).
module video_fb_sdram_arbiter #(
    parameter int AVS_DW          = 16,
    parameter int AVS_AW          = 23,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DISP_HOLD       = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              m0_read,
    input  logic [AVS_AW-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic [AVS_DW-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_write,
    input  logic [AVS_AW-1:0] m1_address,
    input  logic [AVS_DW-1:0] m1_writedata,
    output logic              m1_waitrequest,

    input  logic              m2_read,
    input  logic              m2_write,
    input  logic [AVS_AW-1:0] m2_address,
    input  logic [AVS_DW-1:0] m2_writedata,
    output logic              m2_waitrequest,
    output logic [AVS_DW-1:0] m2_readdata,
    output logic              m2_readdatavalid,

    output logic              s_read,
    output logic              s_write,
    output logic [AVS_AW-1:0] s_address,
    output logic [AVS_DW-1:0] s_writedata,
    input  logic              s_waitrequest,
    input  logic [AVS_DW-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              err_rdv
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int HW = $clog2(DISP_HOLD + 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_M0   = 2'd1;
    localparam logic [1:0] GNT_M1   = 2'd2;
    localparam logic [1:0] GNT_M2   = 2'd3;

    logic                       locked;
    logic [1:0]                 lock_owner;
    logic                       rr_m2;      // 0: m1 has priority next, 1: m2
    logic [HW-1:0]              hold_cnt;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [PW:0]                count;

    logic       fifo_full;
    logic       fifo_empty;
    logic       m2_wr_only;
    logic       other_req;
    logic       m0_elig;
    logic       m2_elig;
    logic       m0_masked;
    logic [1:0] gnt;
    logic       accept;
    logic       push;
    logic       pop;
    logic       head_tag;

    assign fifo_full  = (count == (PW+1)'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign m2_wr_only = m2_write & ~m2_read;
    assign other_req  = m1_write | m2_read | m2_write;
    assign m0_elig    = m0_read & ~fifo_full;
    assign m2_elig    = m2_wr_only | (m2_read & ~fifo_full);
    assign m0_masked  = (hold_cnt == HW'(DISP_HOLD)) & other_req;

    // Grant: stalled owner keeps the bus, else m0 unless masked, else m1/m2 round-robin
    always_comb begin
        gnt = GNT_NONE;
        if (sys_rst) begin
            gnt = GNT_NONE;
        end else if (locked) begin
            gnt = lock_owner;
        end else if (m0_elig && !m0_masked) begin
            gnt = GNT_M0;
        end else if (!rr_m2) begin
            if (m1_write)     gnt = GNT_M1;
            else if (m2_elig) gnt = GNT_M2;
        end else begin
            if (m2_elig)       gnt = GNT_M2;
            else if (m1_write) gnt = GNT_M1;
        end
    end

    // Command mux toward the controller
    always_comb begin
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_address   = '0;
        s_writedata = '0;
        case (gnt)
            GNT_M0: begin
                s_read    = m0_read;
                s_address = m0_address;
            end
            GNT_M1: begin
                s_write     = m1_write;
                s_address   = m1_address;
                s_writedata = m1_writedata;
            end
            GNT_M2: begin
                s_read      = m2_read;
                s_write     = m2_wr_only;
                s_address   = m2_address;
                s_writedata = m2_writedata;
            end
            default: ;
        endcase
    end

    assign m0_waitrequest = (gnt != GNT_M0) | s_waitrequest;
    assign m1_waitrequest = (gnt != GNT_M1) | s_waitrequest;
    assign m2_waitrequest = (gnt != GNT_M2) | s_waitrequest;

    assign accept   = (s_read | s_write) & ~s_waitrequest;
    assign push     = accept & s_read;
    assign pop      = s_readdatavalid & ~fifo_empty & ~sys_rst;
    assign head_tag = tag_mem[rd_ptr];

    assign m0_readdata      = s_readdata;
    assign m2_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_tag;
    assign m2_readdatavalid = pop & head_tag;

    // Lock, round-robin pointer and display fairness counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            locked     <= 1'b0;
            lock_owner <= GNT_NONE;
            rr_m2      <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            locked     <= (s_read | s_write) & s_waitrequest;
            lock_owner <= gnt;
            if (accept && gnt == GNT_M1)      rr_m2 <= 1'b1;
            else if (accept && gnt == GNT_M2) rr_m2 <= 1'b0;
            if ((accept && (gnt == GNT_M1 || gnt == GNT_M2)) || !other_req)
                hold_cnt <= '0;
            else if (accept && gnt == GNT_M0 && hold_cnt != HW'(DISP_HOLD))
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Tag FIFO and sticky orphan-response flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_rdv <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= (gnt == GNT_M2);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_readdatavalid && fifo_empty) err_rdv <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_fb_sdram_arbiter.sv
// Bench for video_fb_sdram_arbiter: random Avalon masters and a random SDRAM
// slave, a queue-based reference model, and a negedge monitor that pops the
// expected per-cycle picture and the per-master read-response scoreboards.
module tb_video_fb_sdram_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 23;
    localparam int MAXO = 8;
    localparam int DH   = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          m0_read, m0_waitrequest, m0_readdatavalid;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_readdata;
    logic          m1_write, m1_waitrequest;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_writedata;
    logic          m2_read, m2_write, m2_waitrequest, m2_readdatavalid;
    logic [AW-1:0] m2_address;
    logic [DW-1:0] m2_writedata, m2_readdata;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata, s_readdata;
    logic          err_rdv;

    always #5 sys_clk = ~sys_clk;

    video_fb_sdram_arbiter #(
        .AVS_DW(DW), .AVS_AW(AW), .MAX_OUTSTANDING(MAXO), .DISP_HOLD(DH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest),
        .m2_read(m2_read), .m2_write(m2_write), .m2_address(m2_address),
        .m2_writedata(m2_writedata), .m2_waitrequest(m2_waitrequest),
        .m2_readdata(m2_readdata), .m2_readdatavalid(m2_readdatavalid),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .err_rdv(err_rdv)
    );

    typedef struct {
        bit            v;
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        bit            s_rd;
        bit            s_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w0, w1, w2;
        bit            v0, v2;
        bit            err;
    } exp_t;

    req_t          pend [3];
    exp_t          exp_q[$];
    logic [DW-1:0] rsp0_q[$];
    logic [DW-1:0] rsp2_q[$];
    logic [AW-1:0] slave_q[$];
    int            obs_q[$];
    int            tags[$];     // issuers of reads in flight, oldest first

    int lock_owner;             // -1 when nobody is stalled on the bus
    int rr_next;                // which of m1/m2 is preferred next
    int run;                    // m0 accepts in a row while m1/m2 wait
    bit model_err;

    int p_req [3];
    int p_wait, p_rdv;
    bit force_rdv;

    int tests = 0;
    int fails = 0;

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return a[DW-1:0] ^ {a[AW-1:DW], 9'h0A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle expected picture plus read-response scoreboards
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("s_read", s_read, e.s_rd);
                check("s_write", s_write, e.s_wr);
                if (e.s_rd || e.s_wr) check("s_address", s_address, e.a);
                if (e.s_wr) check("s_writedata", s_writedata, e.d);
                check("m0_waitrequest", m0_waitrequest, e.w0);
                check("m1_waitrequest", m1_waitrequest, e.w1);
                check("m2_waitrequest", m2_waitrequest, e.w2);
                check("m0_readdatavalid", m0_readdatavalid, e.v0);
                check("m2_readdatavalid", m2_readdatavalid, e.v2);
                check("err_rdv", err_rdv, e.err);
                if (m0_readdatavalid === 1'b1) begin
                    check("m0_rsp_expected", rsp0_q.size() > 0, 1);
                    if (rsp0_q.size() > 0) check("m0_readdata", m0_readdata, rsp0_q.pop_front());
                end
                if (m2_readdatavalid === 1'b1) begin
                    check("m2_rsp_expected", rsp2_q.size() > 0, 1);
                    if (rsp2_q.size() > 0) check("m2_readdata", m2_readdata, rsp2_q.pop_front());
                end
                if ((s_read || s_write) && !s_waitrequest)
                    obs_q.push_back(!m0_waitrequest ? 0 : !m1_waitrequest ? 1 : !m2_waitrequest ? 2 : 3);
            end
        end
    end

    // SDRAM side: remember the address of every accepted read, in order
    initial begin : slave
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && s_read && !s_waitrequest) slave_q.push_back(s_address);
        end
    end

    task automatic set_knobs(input int a, input int b, input int c, input int w, input int r);
        p_req[0] = a; p_req[1] = b; p_req[2] = c; p_wait = w; p_rdv = r;
    endtask

    task automatic do_reset();
        exp_t e;
        sys_rst = 1'b1;
        m0_read = 0; m1_write = 0; m2_read = 0; m2_write = 0;
        m0_address = '0; m1_address = '0; m2_address = '0;
        m1_writedata = '0; m2_writedata = '0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
        for (int i = 0; i < 3; i++) pend[i].v = 0;
        tags.delete(); rsp0_q.delete(); rsp2_q.delete(); slave_q.delete(); obs_q.delete();
        lock_owner = -1; rr_next = 1; run = 0; model_err = 0;
        for (int i = 0; i < 3; i++) begin
            e = '{default: '0};
            e.w0 = 1; e.w1 = 1; e.w2 = 1;
            s_readdatavalid = (i == 1);   // responses must be ignored during reset
            exp_q.push_back(e);
            @(posedge sys_clk); #1;
        end
        s_readdatavalid = 0;
        sys_rst = 1'b0;
    endtask

    task automatic step();
        int   g, hd;
        bit   acc, swait, rdv, room, others, can2;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!pend[i].v && $urandom_range(99) < p_req[i]) begin
                pend[i].v  = 1;
                pend[i].a  = AW'($urandom);
                pend[i].d  = DW'($urandom);
                pend[i].rd = (i == 0) || (i == 2 && $urandom_range(1) == 1);
                pend[i].wr = !pend[i].rd;
            end
        end
        swait = ($urandom_range(99) < p_wait);
        rdv   = force_rdv || (slave_q.size() > 0 && $urandom_range(99) < p_rdv);

        m0_read = pend[0].v; m0_address = pend[0].a;
        m1_write = pend[1].v; m1_address = pend[1].a; m1_writedata = pend[1].d;
        m2_read = pend[2].v && pend[2].rd; m2_write = pend[2].v && pend[2].wr;
        m2_address = pend[2].a; m2_writedata = pend[2].d;
        s_waitrequest = swait;
        s_readdatavalid = rdv;
        s_readdata = (rdv && slave_q.size() > 0) ? rdata_of(slave_q.pop_front()) : DW'($urandom);

        // Who should own the bus this cycle
        room   = tags.size() < MAXO;
        others = pend[1].v || pend[2].v;
        can2   = pend[2].v && (pend[2].wr || room);
        if (lock_owner >= 0)                                 g = lock_owner;
        else if (pend[0].v && room && !(run >= DH && others)) g = 0;
        else if (rr_next == 1)                               g = pend[1].v ? 1 : (can2 ? 2 : -1);
        else                                                 g = can2 ? 2 : (pend[1].v ? 1 : -1);
        acc = (g >= 0) && !swait;

        e = '{default: '0};
        e.w0 = !(g == 0) || swait;
        e.w1 = !(g == 1) || swait;
        e.w2 = !(g == 2) || swait;
        if (g >= 0) begin
            e.s_rd = pend[g].rd; e.s_wr = pend[g].wr; e.a = pend[g].a; e.d = pend[g].d;
        end
        e.err = model_err;
        hd = -1;
        if (rdv) begin
            if (tags.size() > 0) hd = tags.pop_front();
            else                 model_err = 1;
        end
        e.v0 = (hd == 0);
        e.v2 = (hd == 2);
        exp_q.push_back(e);

        if (acc) begin
            if (pend[g].rd) begin
                tags.push_back(g);
                if (g == 0) rsp0_q.push_back(rdata_of(pend[g].a));
                else        rsp2_q.push_back(rdata_of(pend[g].a));
            end
            if (g == 0) begin
                if (others) run = (run < DH) ? run + 1 : DH;
            end else begin
                run = 0;
                rr_next = (g == 1) ? 2 : 1;
            end
            pend[g].v = 0;
        end
        if (!others) run = 0;
        lock_owner = (g >= 0 && swait) ? g : -1;
        @(posedge sys_clk); #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : driver
        int m, want;
        force_rdv = 0;
        sys_rst = 1'b1;
        m0_read = 0; m1_write = 0; m2_read = 0; m2_write = 0;
        m0_address = '0; m1_address = '0; m2_address = '0;
        m1_writedata = '0; m2_writedata = '0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
        @(posedge sys_clk); #1;

        // All three saturating: 16 m0, m1, 16 m0, m2, ...
        do_reset();
        set_knobs(100, 100, 100, 0, 100);
        run_cycles(80);
        check("hold_pattern_len", obs_q.size() >= 68, 1);
        for (int k = 0; k < 68; k++) begin
            m = k % 34;
            want = (m == 16) ? 1 : (m == 33) ? 2 : 0;
            check($sformatf("hold_seq[%0d]", k), (k < obs_q.size()) ? obs_q[k] : -1, want);
        end

        // m1/m2 only: strict alternation starting with m1
        do_reset();
        set_knobs(0, 100, 100, 0, 100);
        run_cycles(20);
        check("rr_pattern_len", obs_q.size() >= 16, 1);
        for (int k = 0; k < 16; k++)
            check($sformatf("rr_seq[%0d]", k), (k < obs_q.size()) ? obs_q[k] : -1, (k % 2 == 0) ? 1 : 2);

        // Stalls and locks with random traffic
        do_reset();
        set_knobs(60, 50, 50, 40, 40);
        run_cycles(600);

        // Fill the tag FIFO with no responses, then let responses drain it
        do_reset();
        set_knobs(100, 30, 0, 0, 0);
        run_cycles(30);
        set_knobs(100, 30, 30, 0, 50);
        run_cycles(40);

        // General random traffic
        do_reset();
        set_knobs(50, 50, 50, 30, 50);
        run_cycles(1500);

        // Orphan response: sticky error, cleared only by reset
        do_reset();
        set_knobs(0, 0, 0, 0, 0);
        run_cycles(2);
        force_rdv = 1;
        run_cycles(1);
        force_rdv = 0;
        run_cycles(5);
        do_reset();
        run_cycles(3);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_fb_sdram_arbiter.md
# video_fb_sdram_arbiter

Three-port Avalon-MM arbiter that shares the single frame-buffer SDRAM controller port between three requesters: the display line fetcher (m0, read-only), the daisy-chain pixel writer (m1, write-only) and the CPU (m2, read/write). It sits between those requesters and the SDRAM controller's Avalon slave in the system clock domain. Commands pass through combinationally. Read responses are routed back to the issuing requester through an in-order tag FIFO.

## Interface
- AVS_DW, 16, Avalon data width
- AVS_AW, 23, Avalon address width
- MAX_OUTSTANDING, 8, tag FIFO depth (max reads in flight); power of two ≥ 2
- DISP_HOLD, 16, max consecutive m0 accepts while m1/m2 are waiting

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- m0_read  in  1  display read request
- m0_address  in  AVS_AW  display address
- m0_waitrequest  out  1  m0 stall
- m0_readdata  out  AVS_DW  display read data
- m0_readdatavalid  out  1  m0 data valid
- m1_write  in  1  pixel write request
- m1_address  in  AVS_AW  pixel address
- m1_writedata  in  AVS_DW  pixel data
- m1_waitrequest  out  1  m1 stall
- m2_read, m2_write  in  1 each  CPU command
- m2_address  in  AVS_AW  CPU address
- m2_writedata  in  AVS_DW  CPU write data
- m2_waitrequest  out  1  m2 stall
- m2_readdata  out  AVS_DW  CPU read data
- m2_readdatavalid  out  1  m2 data valid
- s_read, s_write  out  1 each  command to SDRAM controller
- s_address  out  AVS_AW  command address
- s_writedata  out  AVS_DW  write data
- s_waitrequest  in  1  controller stall
- s_readdata  in  AVS_DW  controller read data
- s_readdatavalid  in  1  controller data valid
- err_rdv  out  1  sticky: readdatavalid received with no outstanding read

## Operation
- Request: m0_read; m1_write; m2_read|m2_write. m2_read and m2_write both high is illegal; read takes precedence.
- A read request is eligible only when the tag FIFO is not full. Writes are always eligible.
- Grant selection happens each cycle when unlocked:
  - m0 wins if eligible and not masked.
  - Otherwise m1 and m2 round-robin by pointer `rr`. `rr` points to the other of the two after an m1 or m2 accept. Reset value of `rr` is m1.
- Accept = (s_read|s_write) & !s_waitrequest.
- Lock: if a command is presented and s_waitrequest=1, register the owner. The next cycle grants that owner unconditionally, and this repeats until the command is accepted. No preemption while stalled.
- Fairness counter `hold_cnt`:
  - Increments on each m0 accept while m1 or m2 is requesting.
  - Clears on an m1/m2 accept, or when no m1/m2 request is present.
  - At DISP_HOLD, m0 is masked until the next m1/m2 accept.
- Mux: s_* carry the granted master's command; s_read/s_write = 0 when there is no grant.
- Waitrequest:
  - The granted master gets s_waitrequest.
  - Non-granted masters get 1.
  - An ineligible reader gets 1.
- Tag FIFO (1 bit: 0 = m0, 1 = m2):
  - Push on read accept.
  - Pop on s_readdatavalid.
  - s_readdata fans out to both readdata outputs.
  - Only the head-tag valid output asserts.
- Full FIFO blocks a new read even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged.
- s_readdatavalid with empty FIFO: data dropped, no valid asserted, err_rdv set until reset.

## Timing
- Command path is zero latency: a request is visible on s_* in the same cycle. Best case is one accept per cycle.
- Response path is zero latency: s_readdatavalid → mX_readdatavalid in the same cycle. Responses return in issue order.
- State changes occur on the sys_clk rising edge: lock, rr, hold_cnt, FIFO, err_rdv.
- While sys_rst is high:
  - s_read=s_write=0.
  - All waitrequest=1.
  - Both readdatavalid=0.
  - err_rdv=0.
  - FIFO empty, lock clear, hold_cnt=0.
- Reset mid-operation discards in-flight tags. The controller is reset by the same signal.

## Test plan
- m0, m1 and m2 request continuously with s_waitrequest=0 and DISP_HOLD=16 → 16 m0 accepts, then 1 m1, then 16 m0, then 1 m2; the pattern repeats.
- m1 and m2 request continuously with m0 idle → strict alternation m1, m2, m1…; first accept is m1 after reset.
- m1 command stalled by s_waitrequest=1 for 5 cycles while m0 raises a read → s_* hold m1's address and data for all 5 cycles; m0 is granted the cycle after m1 is accepted.
- MAX_OUTSTANDING=8, 8 m0 reads accepted with no response → 9th read stalls while an m1 write is accepted. One s_readdatavalid later, the read is accepted.
- Interleaved m0 and m2 reads with tag order 0,1,1,0 and responses D0..D3 → m0 sees D0 and D3; m2 sees D1 and D2.
- s_readdatavalid pulsed with FIFO empty → no mX_readdatavalid; err_rdv=1 persists; sys_rst clears it.
